// File: rtl/cosim_list_pkg.sv
// Shared Cap'n Proto constants, FSM state type and the list-pointer validity check
// used by the cosim receive-side unpacker.
package cosim_list_pkg;

  localparam int          CAPNP_WORD_BITS = 64;
  localparam logic [1:0]  CAPNP_PTR_LIST  = 2'b01;
  localparam logic [2:0]  CAPNP_ELEM_BYTE = 3'd2;

  typedef enum logic {IDLE, SEND} unpack_state_t;

  // A usable pointer is a list of single bytes that fits in the payload buffer.
  function automatic logic list_ptr_ok(input logic [63:0] word, input logic [31:0] max_bytes);
    return (word[1:0] == CAPNP_PTR_LIST) &&
           (word[34:32] == CAPNP_ELEM_BYTE) &&
           ({3'b000, word[63:35]} <= max_bytes);
  endfunction

endpackage

// File: rtl/cosim_list_unpacker.sv
// Accepts one Cap'n Proto byte-list message per handshake and streams its payload
// out one byte per handshake; malformed messages are dropped and counted.
module cosim_list_unpacker
  import cosim_list_pkg::*;
#(
  parameter int DATA_WORDS = 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [64*(2+DATA_WORDS)-1:0]        in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [7:0]                          out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic [ERR_CNT_W-1:0]                err_count
);

  localparam int MSG_BITS  = CAPNP_WORD_BITS * (2 + DATA_WORDS);
  localparam int MAX_BYTES = 8 * DATA_WORDS;
  localparam int IDX_W     = $clog2(MAX_BYTES);
  localparam int CNT_W     = IDX_W + 1;

  unpack_state_t                 state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MAX_BYTES-1:0][7:0]     buf_q, buf_d;
  logic [ERR_CNT_W-1:0]          err_q, err_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic [7:0]                    out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;

  logic                          ptr_ok;
  logic [CNT_W-1:0]              cnt_in;
  logic [IDX_W-1:0]              idx_inc;

  assign ptr_ok  = list_ptr_ok(in_data[127:64], 32'(MAX_BYTES));
  // Only meaningful once ptr_ok has bounded the count to MAX_BYTES.
  assign cnt_in  = CNT_W'(in_data[127:99]);
  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          if (!ptr_ok) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
          end else if (cnt_in != '0) begin
            state_d     = SEND;
            buf_d       = in_data[MSG_BITS-1:128];
            cnt_d       = cnt_in;
            idx_d       = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = in_data[135:128];
            out_last_d  = (cnt_in == CNT_W'(1));
          end
        end
      end
      SEND: begin
        in_ready_d = 1'b0;
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_inc;
            out_data_d = buf_q[idx_inc];
            out_last_d = (CNT_W'(idx_inc) == cnt_q - CNT_W'(1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      err_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SEND);
  assign err_count = err_q;

endmodule

// File: tb/tb_cosim_list_unpacker.sv
// Directed bench for cosim_list_unpacker: a scoreboard queue holds expected bytes
// and a negedge monitor compares every output handshake against it.
module tb_cosim_list_unpacker;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic [15:0]  err_count;

  logic         in_valid4;
  logic         in_ready4;
  logic [191:0] in_data4;
  logic         out_valid4;
  logic         out_ready4;
  logic [7:0]   out_data4;
  logic         out_last4;
  logic         busy4;
  logic [3:0]   err_count4;

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;
  int exp_err  = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  cosim_list_unpacker #(.DATA_WORDS(1), .ERR_CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_count(err_count)
  );

  cosim_list_unpacker #(.DATA_WORDS(1), .ERR_CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4),
    .busy(busy4), .err_count(err_count4)
  );

  // Handshakes complete at the next posedge, so judge them on the negedge before it.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      hs_count++;
      checks++;
      if (sb.size() == 0) begin
        assert (1'b0) else begin
          errors++;
          $error("[TB] FAIL sb_unexpected: observed byte %02h last %0b, expected no byte", out_data, out_last);
        end
      end else begin
        logic [8:0] exp_item;
        exp_item = sb.pop_front();
        assert ({out_last, out_data} === exp_item) else begin
          errors++;
          $error("[TB] FAIL sb_byte: observed last/data %0b/%02h expected %0b/%02h",
                 out_last, out_data, exp_item[8], exp_item[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode of the list pointer; queues the bytes a valid message must produce.
  task automatic model_push(input logic [63:0] w1, input logic [63:0] w2);
    int cnt;
    cnt = int'(w1[63:35]);
    if (w1[1:0] != 2'b01 || w1[34:32] != 3'd2 || cnt > 8) begin
      exp_err++;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        sb.push_back({(k == cnt - 1), w2[8*k +: 8]});
      end
    end
  endtask

  task automatic send_msg(input logic [63:0] w1, input logic [63:0] w2);
    logic ok;
    model_push(w1, w2);
    in_data  = {w2, w1, 64'h0123_4567_89AB_CDEF};
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check_val("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    check_val("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] held_data;
    logic       held_last;
    int         hs_before;
    logic [5:0] pattern;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    in_valid4 = 1'b0;
    in_data4  = '0;
    out_ready4 = 1'b1;
    #12;
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_last", 32'(out_last), 0);
    check_val("rst_out_data", 32'(out_data), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_err", 32'(err_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_val("post_rst_in_ready", 32'(in_ready), 1);

    $display("[TB] test 1: three-byte message, sink always ready");
    send_msg(64'h0000001A_00000001, 64'h00000000_00CCBBAA);
    check_val("t1_b0_valid", 32'(out_valid), 1);
    check_val("t1_b0_data", 32'(out_data), 32'hAA);
    check_val("t1_b0_inrdy", 32'(in_ready), 0);
    check_val("t1_busy", 32'(busy), 1);
    tick();
    check_val("t1_b1_data", 32'(out_data), 32'hBB);
    check_val("t1_b1_last", 32'(out_last), 0);
    check_val("t1_b1_inrdy", 32'(in_ready), 0);
    tick();
    check_val("t1_b2_data", 32'(out_data), 32'hCC);
    check_val("t1_b2_last", 32'(out_last), 1);
    check_val("t1_b2_inrdy", 32'(in_ready), 0);
    tick();
    check_val("t1_done_valid", 32'(out_valid), 0);
    check_val("t1_done_inrdy", 32'(in_ready), 1);
    check_val("t1_sb_empty", sb.size(), 0);

    $display("[TB] test 2: same message with sink stalls");
    hs_before = hs_count;
    pattern = 6'b101001;
    send_msg(64'h0000001A_00000001, 64'h00000000_00CCBBAA);
    for (int i = 0; i < 6; i++) begin
      out_ready = pattern[i];
      held_data = out_data;
      held_last = out_last;
      tick();
      if (!pattern[i]) begin
        check_val("t2_stall_valid", 32'(out_valid), 1);
        check_val("t2_stall_data", 32'(out_data), 32'(held_data));
        check_val("t2_stall_last", 32'(out_last), 32'(held_last));
      end
    end
    out_ready = 1'b1;
    check_val("t2_done_valid", 32'(out_valid), 0);
    check_val("t2_handshakes", hs_count - hs_before, 3);

    $display("[TB] test 3: empty and malformed messages");
    send_msg(64'h00000002_00000001, 64'h00000000_000000EE);
    check_val("t3_cnt0_valid", 32'(out_valid), 0);
    check_val("t3_cnt0_inrdy", 32'(in_ready), 1);
    check_val("t3_cnt0_err", 32'(err_count), 0);
    send_msg(64'h0000004A_00000001, 64'h11223344_55667788);
    check_val("t3_cnt9_valid", 32'(out_valid), 0);
    check_val("t3_cnt9_err", 32'(err_count), 1);
    send_msg(64'h0000001A_00000000, 64'h00000000_00CCBBAA);
    check_val("t3_tag0_valid", 32'(out_valid), 0);
    check_val("t3_tag0_err", 32'(err_count), 2);
    check_val("t3_model_err", 32'(err_count), 32'(exp_err));

    $display("[TB] test 4: back-to-back messages");
    send_msg(64'h0000000A_00000001, 64'h00000000_0000005A);
    check_val("t4_m1_data", 32'(out_data), 32'h5A);
    check_val("t4_m1_last", 32'(out_last), 1);
    tick();
    check_val("t4_gap_valid", 32'(out_valid), 0);
    check_val("t4_gap_inrdy", 32'(in_ready), 1);
    send_msg(64'h00000042_00000001, 64'h08070605_04030201);
    check_val("t4_m2_first", 32'(out_data), 32'h01);
    wait_drain();
    tick();
    check_val("t4_done_valid", 32'(out_valid), 0);

    $display("[TB] test 5: reset in the middle of a message");
    send_msg(64'h0000001A_00000001, 64'h00000000_00CCBBAA);
    tick();
    check_val("t5_idx1_data", 32'(out_data), 32'hBB);
    rstn = 1'b0;
    sb.delete();
    exp_err = 0;
    #1;
    check_val("t5_rst_valid", 32'(out_valid), 0);
    check_val("t5_rst_last", 32'(out_last), 0);
    check_val("t5_rst_inrdy", 32'(in_ready), 0);
    check_val("t5_rst_busy", 32'(busy), 0);
    check_val("t5_rst_err", 32'(err_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_val("t5_rel_inrdy", 32'(in_ready), 1);
    send_msg(64'h0000001A_00000001, 64'h00000000_00332211);
    check_val("t5_restart_data", 32'(out_data), 32'h11);
    wait_drain();

    $display("[TB] test 6: saturating error counter on 4-bit build");
    in_data4  = {64'h0, 64'h0000001A_00000000, 64'h0};
    in_valid4 = 1'b1;
    repeat (14) tick();
    check_val("t6_err14", 32'(err_count4), 32'hE);
    tick();
    check_val("t6_err15", 32'(err_count4), 32'hF);
    repeat (3) tick();
    check_val("t6_err_hold", 32'(err_count4), 32'hF);
    check_val("t6_no_valid", 32'(out_valid4), 0);
    in_valid4 = 1'b0;

    check_val("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
